// File: rtl/game_pkg.sv
// Shared game constants and the vertical-motion state encoding.
package game_pkg;

    localparam int unsigned COORD_W = 9;
    localparam int unsigned CALC_W  = COORD_W + 1;
    localparam int unsigned VEL_W   = 5;
    localparam int unsigned CHAR_H  = 16;

    typedef enum logic [1:0] {
        ST_GROUNDED = 2'b00,
        ST_RISING   = 2'b01,
        ST_FALLING  = 2'b10,
        ST_UNUSED   = 2'b11
    } state_e;

endpackage

// File: rtl/char_jump_ctrl.sv
// Vertical-motion controller for the 16x16 player character: rise/fall state
// machine advancing once per frame tick, producing the absolute top-edge Y.
module char_jump_ctrl
    import game_pkg::*;
#(
    parameter logic [COORD_W-1:0] INIT_Y     = 9'd184,
    parameter logic [VEL_W-1:0]   JUMP_V0    = 5'd6,
    parameter logic [VEL_W-1:0]   SPRING_V0  = 5'd10,
    parameter logic [VEL_W-1:0]   MAX_FALL_V = 5'd8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               tick,
    input  logic               spring_jump,
    input  logic               btn_jump,
    input  logic [COORD_W-1:0] floor_Y,
    output logic [COORD_W-1:0] char_Y,
    output logic [VEL_W-1:0]   vel,
    output logic [1:0]         state,
    output logic               airborne,
    output logic               jump_ack
);

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [VEL_W-1:0]     vel_q, vel_d;
    logic                 air_q;
    logic                 ack_q, ack_d;

    logic [CALC_W-1:0]    y_ext, vel_ext, floor_ext;
    logic [CALC_W-1:0]    fall_inc;
    logic [VEL_W-1:0]     fall_v;
    logic [COORD_W-1:0]   land_y;

    assign char_Y   = y_q;
    assign vel      = vel_q;
    assign state    = state_q;
    assign airborne = air_q;
    assign jump_ack = ack_q;

    // Shared 10-bit operands: candidate fall speed and snapped landing Y.
    always_comb begin
        y_ext     = CALC_W'(y_q);
        vel_ext   = CALC_W'(vel_q);
        floor_ext = CALC_W'(floor_Y);
        // The unused encoding behaves as FALLING from rest.
        fall_inc  = (state_q == ST_FALLING) ? vel_ext + CALC_W'(1) : CALC_W'(1);
        fall_v    = (fall_inc > CALC_W'(MAX_FALL_V)) ? MAX_FALL_V : VEL_W'(fall_inc);
        land_y    = (floor_ext >= CALC_W'(CHAR_H)) ?
                    COORD_W'(floor_ext - CALC_W'(CHAR_H)) : '0;
    end

    // Next-state and next-value logic; everything holds between ticks.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        ack_d   = 1'b0;
        if (tick) begin
            case (state_q)
                ST_GROUNDED: begin
                    if (spring_jump) begin
                        vel_d   = SPRING_V0;
                        state_d = ST_RISING;
                        ack_d   = 1'b1;
                    end else if (btn_jump) begin
                        vel_d   = JUMP_V0;
                        state_d = ST_RISING;
                        ack_d   = 1'b1;
                    end else if (y_ext + CALC_W'(CHAR_H) < floor_ext) begin
                        vel_d   = '0;
                        state_d = ST_FALLING;
                    end
                end
                ST_RISING: begin
                    if (y_ext < vel_ext || vel_q == '0) begin
                        // Head hit the top of the screen (or nothing left to rise).
                        y_d     = (y_ext < vel_ext) ? '0 : y_q;
                        vel_d   = '0;
                        state_d = ST_FALLING;
                    end else begin
                        y_d   = COORD_W'(y_ext - vel_ext);
                        vel_d = vel_q - VEL_W'(1);
                        if (vel_q == VEL_W'(1)) begin
                            state_d = ST_FALLING;
                        end
                    end
                end
                default: begin
                    if (y_ext + CALC_W'(CHAR_H) + CALC_W'(fall_v) >= floor_ext) begin
                        y_d     = land_y;
                        vel_d   = '0;
                        state_d = ST_GROUNDED;
                    end else begin
                        y_d     = COORD_W'(y_ext + CALC_W'(fall_v));
                        vel_d   = fall_v;
                        state_d = ST_FALLING;
                    end
                end
            endcase
        end
    end

    // State, position and velocity registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_GROUNDED;
            y_q     <= INIT_Y;
            vel_q   <= '0;
            air_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            air_q   <= (state_d != ST_GROUNDED);
            ack_q   <= ack_d;
        end
    end

endmodule

// File: tb/tb_char_jump_ctrl.sv
// Self-checking bench for char_jump_ctrl: directed scenarios plus random
// stimulus against a behavioural motion model.
module tb_char_jump_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       tick;
    logic       spring_jump;
    logic       btn_jump;
    logic [8:0] floor_Y;
    logic [8:0] char_Y;
    logic [4:0] vel;
    logic [1:0] state;
    logic       airborne;
    logic       jump_ack;

    int checks;
    int failures;

    // Reference model: position, speed, phase (0 ground, 1 up, 2 down), ack.
    int m_y, m_v, m_st, m_ack;

    char_jump_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .tick        (tick),
        .spring_jump (spring_jump),
        .btn_jump    (btn_jump),
        .floor_Y     (floor_Y),
        .char_Y      (char_Y),
        .vel         (vel),
        .state       (state),
        .airborne    (airborne),
        .jump_ack    (jump_ack)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic model_reset();
        m_y = 184; m_v = 0; m_st = 0; m_ack = 0;
    endtask

    task automatic model_step(input bit t, input bit s, input bit b, input int f);
        int nv;
        m_ack = 0;
        if (!t) return;
        if (m_st == 0) begin
            if (s)      begin m_v = 10; m_st = 1; m_ack = 1; end
            else if (b) begin m_v = 6;  m_st = 1; m_ack = 1; end
            else if (m_y + 16 < f) begin m_v = 0; m_st = 2; end
        end else if (m_st == 1) begin
            if (m_y < m_v) begin m_y = 0; m_v = 0; m_st = 2; end
            else begin
                m_y = m_y - m_v;
                m_v = m_v - 1;
                if (m_v == 0) m_st = 2;
            end
        end else begin
            nv = (m_v + 1 > 8) ? 8 : m_v + 1;
            if (m_y + 16 + nv >= f) begin
                m_y = (f - 16 < 0) ? 0 : f - 16;
                m_v = 0; m_st = 0;
            end else begin
                m_y = m_y + nv; m_v = nv;
            end
        end
    endtask

    task automatic apply_reset(input logic [8:0] f);
        sys_rst_n = 1'b0; tick = 1'b0; spring_jump = 1'b0; btn_jump = 1'b0;
        floor_Y = f;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_cycle(input bit t, input bit s, input bit b, input logic [8:0] f);
        tick = t; spring_jump = s; btn_jump = b; floor_Y = f;
        @(posedge sys_clk);
        model_step(t, s, b, int'(f));
        #1;
    endtask

    task automatic test_reset();
        apply_reset(9'd200);
        checks++;
        if (char_Y !== 9'd184 || vel !== 5'd0 || state !== 2'b00 ||
            airborne !== 1'b0 || jump_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset: char_Y=%0d vel=%0d state=%0d air=%0b ack=%0b, want 184 0 0 0 0",
                     char_Y, vel, state, airborne, jump_ack);
        end
        // No tick: nothing moves even with requests up.
        do_cycle(0, 1, 1, 9'd240);
        checks++;
        if (char_Y !== 9'd184 || state !== 2'b00 || jump_ack !== 1'b0) begin
            failures++;
            $display("FAIL no_tick_hold: char_Y=%0d state=%0d ack=%0b, want 184 0 0",
                     char_Y, state, jump_ack);
        end
    endtask

    task automatic test_button_jump();
        int peak, peak_tick, land_tick, acks, bad;
        apply_reset(9'd200);
        do_cycle(1, 0, 1, 9'd200);
        checks++;
        if (jump_ack !== 1'b1 || state !== 2'b01 || vel !== 5'd6 || char_Y !== 9'd184) begin
            failures++;
            $display("FAIL btn_launch: ack=%0b state=%0d vel=%0d char_Y=%0d, want 1 1 6 184",
                     jump_ack, state, vel, char_Y);
        end
        peak = 999; peak_tick = -1; land_tick = -1; acks = int'(jump_ack); bad = 0;
        for (int i = 1; i <= 40 && land_tick < 0; i++) begin
            do_cycle(1, 0, 0, 9'd200);
            if (char_Y !== 9'(m_y) || vel !== 5'(m_v) || state !== 2'(m_st)) bad++;
            if (int'(char_Y) < peak) begin peak = int'(char_Y); peak_tick = i; end
            acks += int'(jump_ack);
            if (state == 2'b00) land_tick = i;
        end
        checks++;
        if (peak != 163 || peak_tick != 6) begin
            failures++;
            $display("FAIL btn_peak: peak=%0d at tick %0d, want 163 at 6", peak, peak_tick);
        end
        checks++;
        if (land_tick != 12 || char_Y !== 9'd184) begin
            failures++;
            $display("FAIL btn_land: tick=%0d char_Y=%0d, want 12 184", land_tick, char_Y);
        end
        checks++;
        if (acks != 1 || bad != 0) begin
            failures++;
            $display("FAIL btn_ack_model: acks=%0d model_diffs=%0d, want 1 0", acks, bad);
        end
    endtask

    task automatic test_spring_priority();
        int peak, peak_tick, acks, landed;
        apply_reset(9'd200);
        do_cycle(1, 1, 1, 9'd200);
        checks++;
        if (vel !== 5'd10 || state !== 2'b01 || jump_ack !== 1'b1) begin
            failures++;
            $display("FAIL spring_launch: vel=%0d state=%0d ack=%0b, want 10 1 1",
                     vel, state, jump_ack);
        end
        peak = 999; peak_tick = -1; acks = int'(jump_ack); landed = 0;
        for (int i = 1; i <= 60 && landed == 0; i++) begin
            do_cycle(1, 0, 0, 9'd200);
            if (int'(char_Y) < peak) begin peak = int'(char_Y); peak_tick = i; end
            acks += int'(jump_ack);
            if (state == 2'b00) landed = 1;
        end
        checks++;
        if (peak != 129 || peak_tick != 10 || acks != 1) begin
            failures++;
            $display("FAIL spring_peak: peak=%0d tick=%0d acks=%0d, want 129 10 1",
                     peak, peak_tick, acks);
        end
        checks++;
        if (landed != 1 || char_Y !== 9'd184) begin
            failures++;
            $display("FAIL spring_land: landed=%0d char_Y=%0d, want 1 184", landed, char_Y);
        end
    endtask

    task automatic test_ceiling();
        int landed;
        apply_reset(9'd200);
        landed = 0;
        do_cycle(1, 0, 1, 9'd20);
        for (int i = 0; i < 30 && landed == 0; i++) begin
            do_cycle(1, 0, 0, 9'd20);
            if (state == 2'b00) landed = 1;
        end
        checks++;
        if (landed != 1 || char_Y !== 9'd4) begin
            failures++;
            $display("FAIL ceil_setup: landed=%0d char_Y=%0d, want 1 4", landed, char_Y);
        end
        do_cycle(1, 1, 0, 9'd20);
        do_cycle(1, 0, 0, 9'd20);
        checks++;
        if (char_Y !== 9'd0 || state !== 2'b10 || vel !== 5'd0) begin
            failures++;
            $display("FAIL ceil_hit: char_Y=%0d state=%0d vel=%0d, want 0 2 0",
                     char_Y, state, vel);
        end
        landed = 0;
        for (int i = 0; i < 30 && landed == 0; i++) begin
            do_cycle(1, 0, 0, 9'd20);
            if (state == 2'b00) landed = 1;
        end
        checks++;
        if (landed != 1 || char_Y !== 9'd4) begin
            failures++;
            $display("FAIL ceil_land: landed=%0d char_Y=%0d, want 1 4", landed, char_Y);
        end
    endtask

    task automatic test_walk_off();
        int max_v, landed;
        apply_reset(9'd200);
        do_cycle(1, 0, 0, 9'd240);
        checks++;
        if (state !== 2'b10 || vel !== 5'd0 || char_Y !== 9'd184 || airborne !== 1'b1) begin
            failures++;
            $display("FAIL walk_off: state=%0d vel=%0d char_Y=%0d air=%0b, want 2 0 184 1",
                     state, vel, char_Y, airborne);
        end
        max_v = 0; landed = 0;
        for (int i = 0; i < 30 && landed == 0; i++) begin
            do_cycle(1, 0, 0, 9'd240);
            if (int'(vel) > max_v) max_v = int'(vel);
            if (state == 2'b00) landed = 1;
        end
        checks++;
        if (max_v != 8 || landed != 1 || char_Y !== 9'd224) begin
            failures++;
            $display("FAIL walk_land: max_v=%0d landed=%0d char_Y=%0d, want 8 1 224",
                     max_v, landed, char_Y);
        end
    endtask

    task automatic test_held_button();
        int acks, second;
        apply_reset(9'd200);
        acks = 0; second = -1;
        for (int i = 1; i <= 30; i++) begin
            do_cycle(1, 0, 1, 9'd200);
            if (jump_ack === 1'b1) begin
                acks++;
                if (acks == 2) second = i;
            end
        end
        checks++;
        if (acks != 3 || second != 14) begin
            failures++;
            $display("FAIL held_btn: acks=%0d second_at=%0d, want 3 14", acks, second);
        end
    endtask

    task automatic test_async_reset_mid_rise();
        apply_reset(9'd200);
        do_cycle(1, 0, 1, 9'd200);
        do_cycle(1, 0, 1, 9'd200);
        do_cycle(1, 0, 1, 9'd200);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if (char_Y !== 9'd184 || vel !== 5'd0 || state !== 2'b00 ||
            airborne !== 1'b0 || jump_ack !== 1'b0) begin
            failures++;
            $display("FAIL async_rst: char_Y=%0d vel=%0d state=%0d air=%0b ack=%0b, want 184 0 0 0 0",
                     char_Y, vel, state, airborne, jump_ack);
        end
        apply_reset(9'd200);
    endtask

    task automatic test_random();
        int sel, bad_first;
        logic [8:0] f;
        bit t, s, b;
        apply_reset(9'd200);
        bad_first = 0;
        for (int i = 0; i < 600; i++) begin
            t = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 9) == 0);
            b = ($urandom_range(0, 4) == 0);
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       f = 9'd200;
                1:       f = 9'($urandom_range(100, 300));
                2:       f = 9'($urandom_range(0, 511));
                default: f = 9'($urandom_range(0, 40));
            endcase
            do_cycle(t, s, b, f);
            checks++;
            if (char_Y !== 9'(m_y) || vel !== 5'(m_v) || state !== 2'(m_st) ||
                airborne !== (m_st != 0) || jump_ack !== 1'(m_ack)) begin
                failures++;
                if (bad_first < 5)
                    $display("FAIL random c%0d: y=%0d/%0d v=%0d/%0d st=%0d/%0d ack=%0b/%0d",
                             i, char_Y, m_y, vel, m_v, state, m_st, jump_ack, m_ack);
                bad_first++;
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        sys_rst_n = 1'b0; tick = 1'b0; spring_jump = 1'b0; btn_jump = 1'b0;
        floor_Y = 9'd200;
        model_reset();
        test_reset();
        test_button_jump();
        test_spring_priority();
        test_ceiling();
        test_walk_off();
        test_held_button();
        test_async_reset_mid_rise();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
